// File: rtl/store_proc_pkg.sv
//------------------------------------------------------------------------------
// store_proc_pkg
//   Opcode/funct3 encodings, store size masks and FSM states for store_proc.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package store_proc_pkg;

    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;

    localparam logic [2:0] FNC_SB = 3'b000;
    localparam logic [2:0] FNC_SH = 3'b001;
    localparam logic [2:0] FNC_SW = 3'b010;

    localparam logic [7:0] SMASK_B = 8'h01;
    localparam logic [7:0] SMASK_H = 8'h03;
    localparam logic [7:0] SMASK_W = 8'h0F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/store_proc_lane_align.sv
//------------------------------------------------------------------------------
// store_lane_align
//   Combinational byte-lane alignment of a store into a two-word window.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module store_lane_align
    import store_proc_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] store_data_i,
    output logic [7:0]  m8_o,
    output logic [63:0] d64_o,
    output logic        split_o,
    output logic        f3_ok_o
);

    logic [7:0]  w_size_mask;
    logic [31:0] w_data_masked;

    always_comb begin
        w_size_mask = 8'h00;
        f3_ok_o     = 1'b1;
        case (funct3_i)
            FNC_SB:  w_size_mask = SMASK_B;
            FNC_SH:  w_size_mask = SMASK_H;
            FNC_SW:  w_size_mask = SMASK_W;
            default: f3_ok_o     = 1'b0;
        endcase
    end

    // Bytes beyond the access size are forced to zero so disabled lanes carry 0.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_data_masked[8*i +: 8] = w_size_mask[i] ? store_data_i[8*i +: 8] : 8'h00;
    end

    assign m8_o    = w_size_mask << off_i;
    assign d64_o   = {32'h0, w_data_masked} << {off_i, 3'b000};
    assign split_o = |m8_o[7:4];

endmodule

`default_nettype wire

// File: rtl/store_proc.sv
//------------------------------------------------------------------------------
// store_proc
//   Converts store requests into word-aligned write beats, splitting stores
//   that cross a word boundary into a low and a high beat.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module store_proc
    import store_proc_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       store_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_we,
    output logic              store_err,
    output logic              busy
);

    state_e              state_q;
    logic                mem_valid_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [3:0]          mem_we_q;
    logic                store_err_q;
    logic                busy_q;
    logic                split_q;
    logic [ADDR_W-1:0]   hi_addr_q;
    logic [31:0]         hi_wdata_q;
    logic [3:0]          hi_we_q;

    logic [7:0]          w_m8;
    logic [63:0]         w_d64;
    logic                w_split;
    logic                w_f3_ok;
    logic [ADDR_W-1:0]   w_lo_addr;

    store_lane_align u_align (
        .funct3_i     (funct3),
        .off_i        (address[1:0]),
        .store_data_i (store_data),
        .m8_o         (w_m8),
        .d64_o        (w_d64),
        .split_o      (w_split),
        .f3_ok_o      (w_f3_ok)
    );

    assign w_lo_addr = {address[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= '0;
            store_err_q <= 1'b0;
            busy_q      <= 1'b0;
            split_q     <= 1'b0;
            hi_addr_q   <= '0;
            hi_wdata_q  <= '0;
            hi_we_q     <= '0;
        end else begin
            store_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Non-store opcodes are consumed silently.
                    if (req_valid && (opcode == OPC_STORE)) begin
                        if (!w_f3_ok || (w_split && !SPLIT_EN)) begin
                            store_err_q <= 1'b1;
                        end else begin
                            state_q     <= ST_LO;
                            busy_q      <= 1'b1;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= w_lo_addr;
                            mem_wdata_q <= w_d64[31:0];
                            mem_we_q    <= w_m8[3:0];
                            split_q     <= w_split;
                            hi_addr_q   <= w_lo_addr + ADDR_W'(4);
                            hi_wdata_q  <= w_d64[63:32];
                            hi_we_q     <= w_m8[7:4];
                        end
                    end
                end
                ST_LO: begin
                    if (mem_ready) begin
                        if (split_q) begin
                            state_q     <= ST_HI;
                            mem_addr_q  <= hi_addr_q;
                            mem_wdata_q <= hi_wdata_q;
                            mem_we_q    <= hi_we_q;
                        end else begin
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                            mem_valid_q <= 1'b0;
                            mem_we_q    <= '0;
                        end
                    end
                end
                ST_HI: begin
                    if (mem_ready) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= '0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    mem_valid_q <= 1'b0;
                    mem_we_q    <= '0;
                end
            endcase
        end
    end

    assign req_ready = !busy_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign store_err = store_err_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_store_proc.sv
//------------------------------------------------------------------------------
// tb_store_proc
//   Scoreboard bench for store_proc: SPLIT_EN=1 and SPLIT_EN=0 instances.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_store_proc;
    import store_proc_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_valid0 = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] address = '0, store_data = '0;
    logic        mem_ready = 1'b1;

    logic        req_ready, mem_valid, store_err, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_we;
    logic        req_ready0, mem_valid0, store_err0, busy0;
    logic [31:0] mem_addr0, mem_wdata0;
    logic [3:0]  mem_we0;

    beat_t sb_q[$];
    beat_t sb0_q[$];
    int    err_q  = 0;
    int    err0_q = 0;
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    store_proc #(.SPLIT_EN(1'b1), .ADDR_W(32)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .opcode(opcode), .funct3(funct3), .address(address), .store_data(store_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .store_err(store_err), .busy(busy)
    );

    store_proc #(.SPLIT_EN(1'b0), .ADDR_W(32)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .opcode(opcode), .funct3(funct3), .address(address), .store_data(store_data),
        .mem_valid(mem_valid0), .mem_ready(mem_ready), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_we(mem_we0), .store_err(store_err0), .busy(busy0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: compare presented beats against the queue head, pop on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_valid) begin
                chk("beat_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    chk("beat_addr",  64'(mem_addr),  64'(sb_q[0].addr));
                    chk("beat_wdata", 64'(mem_wdata), 64'(sb_q[0].wdata));
                    chk("beat_we",    64'(mem_we),    64'(sb_q[0].we));
                    chk("ready_low",  64'(req_ready), 64'd0);
                    if (mem_ready) void'(sb_q.pop_front());
                end
            end else begin
                chk("we_idle", 64'(mem_we), 64'd0);
            end
            if (store_err) begin
                chk("err_expected", 64'(err_q > 0), 64'd1);
                if (err_q > 0) err_q--;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_valid0) begin
                chk("beat0_expected", 64'(sb0_q.size() != 0), 64'd1);
                if (sb0_q.size() != 0) begin
                    chk("beat0_addr",  64'(mem_addr0),  64'(sb0_q[0].addr));
                    chk("beat0_wdata", 64'(mem_wdata0), 64'(sb0_q[0].wdata));
                    chk("beat0_we",    64'(mem_we0),    64'(sb0_q[0].we));
                    if (mem_ready) void'(sb0_q.pop_front());
                end
            end else begin
                chk("we0_idle", 64'(mem_we0), 64'd0);
            end
            if (store_err0) begin
                chk("err0_expected", 64'(err0_q > 0), 64'd1);
                if (err0_q > 0) err0_q--;
            end
        end
    end

    task automatic send(input bit sel, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        opcode = op; funct3 = f3; address = a; store_data = d;
        if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((sel ? req_ready0 : req_ready) == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", 64'(ok), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_valid0 = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && sb0_q.size() == 0 && req_ready && req_ready0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", 64'(ok), 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(mem_valid), 64'd0);
        chk("rst_addr",  64'(mem_addr),  64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_we",    64'(mem_we),    64'd0);
        chk("rst_err",   64'(store_err), 64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1; rst = 1'b0;

        // Aligned word
        sb_q.push_back('{32'h0000_1000, 32'hDEAD_BEEF, 4'b1111});
        send(1'b0, OPC_STORE, FNC_SW, 32'h0000_1000, 32'hDEAD_BEEF);
        chk("latency_sw", 64'(mem_valid), 64'd1);
        chk("busy_sw",    64'(busy),      64'd1);
        wait_idle();

        // Byte in top lane
        sb_q.push_back('{32'h0000_1000, 32'hAB00_0000, 4'b1000});
        send(1'b0, OPC_STORE, FNC_SB, 32'h0000_1003, 32'h1234_56AB);
        chk("latency_sb", 64'(mem_valid), 64'd1);
        wait_idle();

        // Split halfword
        sb_q.push_back('{32'h0000_1000, 32'hFE00_0000, 4'b1000});
        sb_q.push_back('{32'h0000_1004, 32'h0000_00CA, 4'b0001});
        send(1'b0, OPC_STORE, FNC_SH, 32'h0000_1003, 32'h0000_CAFE);
        wait_idle();

        // Split word wrapping the address space, stalled 3 cycles per beat
        mem_ready = 1'b0;
        sb_q.push_back('{32'hFFFF_FFFC, 32'h3344_0000, 4'b1100});
        sb_q.push_back('{32'h0000_0000, 32'h0000_1122, 4'b0011});
        send(1'b0, OPC_STORE, FNC_SW, 32'hFFFF_FFFE, 32'h1122_3344);
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b1;
        wait_idle();

        // Illegal funct3
        err_q++;
        send(1'b0, OPC_STORE, 3'b011, 32'h0000_1000, 32'h0);
        chk("f3_no_beat", 64'(mem_valid), 64'd0);
        chk("f3_err",     64'(store_err), 64'd1);
        repeat (3) @(posedge clk);
        chk("f3_err_seen", 64'(err_q), 64'd0);

        // Non-store opcode consumed silently
        send(1'b0, OPC_LOAD, FNC_SW, 32'h0000_1000, 32'h5555_5555);
        chk("load_no_beat", 64'(mem_valid), 64'd0);
        chk("load_no_err",  64'(store_err), 64'd0);
        repeat (3) @(posedge clk);

        // SPLIT_EN=0: crossing word dropped with error, non-crossing byte still issued
        err0_q++;
        send(1'b1, OPC_STORE, FNC_SW, 32'h0000_2001, 32'hA5A5_A5A5);
        chk("nosplit_no_beat", 64'(mem_valid0), 64'd0);
        repeat (3) @(posedge clk);
        chk("nosplit_err_seen", 64'(err0_q), 64'd0);
        sb0_q.push_back('{32'h0000_2000, 32'h0000_5500, 4'b0010});
        send(1'b1, OPC_STORE, FNC_SB, 32'h0000_2001, 32'hFFFF_FF55);
        wait_idle();

        // Asynchronous reset during LO of a split store
        mem_ready = 1'b0;
        sb_q.push_back('{32'h0000_1000, 32'hFE00_0000, 4'b1000});
        sb_q.push_back('{32'h0000_1004, 32'h0000_00CA, 4'b0001});
        send(1'b0, OPC_STORE, FNC_SH, 32'h0000_1003, 32'h0000_CAFE);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(mem_valid), 64'd0);
        chk("arst_we",    64'(mem_we),    64'd0);
        chk("arst_busy",  64'(busy),      64'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_no_hi", 64'(mem_valid), 64'd0);

        chk("sb_empty",  64'(sb_q.size() + sb0_q.size()), 64'd0);
        chk("err_empty", 64'(err_q + err0_q), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/store_proc.md
Name: store_proc

Overview:
- Store-side counterpart of the load masking path.
- Accepts one store request per handshake from the memory stage.
- Converts it into word-aligned write beats (word address, lane-shifted data, 4-bit byte write-enable) for Dmem/UART.
- Stores that cross a word boundary are split into two sequential beats. Sits between the execute/memory stage and the Dmem/MMIO write port.

Parameters:
- SPLIT_EN, 1: 1 = split boundary-crossing stores into two beats; 0 = drop them and flag an error.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  store request valid
- req_ready  out  1  block can accept a request
- opcode  in  7  instruction opcode of the request
- funct3  in  3  store width (FNC_SB/FNC_SH/FNC_SW)
- address  in  ADDR_W  byte address
- store_data  in  32  rs2 value, data in low bits
- mem_valid  out  1  write beat valid
- mem_ready  in  1  memory accepted beat
- mem_addr  out  ADDR_W  word-aligned beat address (bits [1:0]=0)
- mem_wdata  out  32  lane-shifted write data
- mem_we  out  4  byte write enables, bit i = byte lane i
- store_err  out  1  one-cycle pulse on rejected store
- busy  out  1  high while not IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
  - While rst is asserted: state=IDLE, mem_valid=0, mem_addr=0, mem_wdata=0, mem_we=0, store_err=0, busy=0.
  - Reset mid-transaction aborts it immediately. A pending HI beat is never issued.
- States: IDLE, LO, HI.
  - req_ready = (state==IDLE). There is no combinational bypass.
- Accept = req_valid & req_ready.
  - opcode != OPC_STORE: request consumed; no beat, no error.
  - funct3 not in {SB, SH, SW}: consumed; store_err pulses the next cycle; stay IDLE.
- Lane computation:
  - off = address[1:0].
  - size_mask = 8'h01 (SB), 8'h03 (SH), 8'h0F (SW).
  - m8 = size_mask << off.
  - d64 = {32'b0, data_masked} << (8*off), where data_masked zeroes bytes beyond the size.
  - Low beat: addr = {address[ADDR_W-1:2], 2'b00}, we = m8[3:0], wdata = d64[31:0].
  - High beat: addr = low addr + 4 (wraps 0xFFFFFFFC -> 0x00000000), we = m8[7:4], wdata = d64[63:32].
  - split = |m8[7:4].
  - Bytes with we=0 carry 0 in mem_wdata.
- Valid store accept:
  - If split && !SPLIT_EN: store_err pulses, no beat, stay IDLE.
  - Otherwise: register both beats and go to LO. mem_valid rises the cycle after accept (latency 1).
- LO: mem_valid=1, drives the low beat.
  - On mem_ready: go to HI if split, else IDLE.
- HI: mem_valid=1, drives the high beat.
  - On mem_ready: go to IDLE.
- While mem_valid & !mem_ready, mem_addr/mem_wdata/mem_we are held stable.
- A new request can be accepted the cycle after the final beat completes; the next beat then appears one cycle after that.
- All outputs are registered. mem_we=0 whenever mem_valid=0.

Decomposition:
- Shared header (alongside Opcode.vh): state encodings for IDLE/LO/HI and the size-mask constants. OPC_STORE and FNC_SB/SH/SW are reused from Opcode.vh.
- One natural sub-module: store_lane_align. It is purely combinational: funct3/off/store_data -> m8, d64, split, funct3-valid. store_proc holds the FSM and the output registers.

Test Plan:
- SW to 0x1000, data 0xDEADBEEF, mem_ready=1 -> one beat one cycle after accept: addr 0x1000, we 4'b1111, wdata 0xDEADBEEF; then IDLE.
- SB to 0x1003, data 0x123456AB -> addr 0x1000, we 4'b1000, wdata 0xAB000000.
- SH to 0x1003, data 0x0000CAFE, SPLIT_EN=1 -> beat 1: addr 0x1000, we 4'b1000, wdata 0xFE000000. Beat 2: addr 0x1004, we 4'b0001, wdata 0x000000CA. req_ready low throughout.
- SW to 0xFFFFFFFE, data 0x11223344, mem_ready held low 3 cycles on each beat -> outputs stable while stalled. Beat 1: addr 0xFFFFFFFC, we 4'b1100, wdata 0x33440000. Beat 2: addr 0x00000000, we 4'b0011, wdata 0x00001122.
- SPLIT_EN=0, SW to 0x2001 -> store_err one-cycle pulse, mem_valid stays 0. Also funct3=3'b011 with OPC_STORE -> store_err pulse. Also opcode OPC_LOAD -> consumed, no beat, no error.
- rst asserted asynchronously during LO of a split store -> mem_valid/mem_we drop immediately. After release: IDLE, req_ready=1, no HI beat issued.
